// File: rtl/rtc_scan_sequencer_if.sv
// rtc_scan_sequencer_if
//   Bundles the RTC read/write controller handshake, the RTC interrupt, the
//   front-panel buttons and the scan/menu status outputs.
//   master : sequencer side (receives i_*, drives o_*)
//   slave  : RTC controller / front-panel side (drives i_*, receives o_*)
//   i_frw        controller done, 1-cycle pulse
//   i_irq        RTC interrupt, active low
//   i_barriba    button up    (level, debounced)
//   i_babajo     button down  (level, debounced)
//   i_bizquierda button left  (level, debounced)
//   i_bderecha   button right (level, debounced)
//   o_acceso     access request, held until i_frw or timeout
//   o_mod        write-back pending
//   o_dir        address being accessed
//   o_punt       edit pointer
//   o_scan_done  1-cycle pulse after each full sweep
//   o_timeout    sticky access timeout flag
interface rtc_scan_sequencer_if #(
   parameter int unsigned ADDR_W = 8
);
   logic              i_frw;
   logic              i_irq;
   logic              i_barriba;
   logic              i_babajo;
   logic              i_bizquierda;
   logic              i_bderecha;
   logic              o_acceso;
   logic              o_mod;
   logic [ADDR_W-1:0] o_dir;
   logic [ADDR_W-1:0] o_punt;
   logic              o_scan_done;
   logic              o_timeout;

   modport master (
      input  i_frw, i_irq, i_barriba, i_babajo, i_bizquierda, i_bderecha,
      output o_acceso, o_mod, o_dir, o_punt, o_scan_done, o_timeout
   );

   modport slave (
      output i_frw, i_irq, i_barriba, i_babajo, i_bizquierda, i_bderecha,
      input  o_acceso, o_mod, o_dir, o_punt, o_scan_done, o_timeout
   );
endinterface

// File: rtl/rtc_scan_sequencer.sv
// rtc_scan_sequencer
//   Sweeps N_WIN address windows through the RTC read/write controller,
//   appends CMD_ADDR when a write-back is pending, and keeps a button-driven
//   edit pointer that wraps across the windows.
//   i_clk  system clock
//   i_rst  asynchronous active-high reset
//   bus    rtc_scan_sequencer_if.master (handshake, IRQ, buttons, status)
module rtc_scan_sequencer #(
   parameter int unsigned               ADDR_W    = 8,
   parameter int unsigned               N_WIN     = 3,
   parameter logic [2*ADDR_W*N_WIN-1:0] WIN_TABLE = {8'h41, 8'h43, 8'h21, 8'h26, 8'h00, 8'h02},
   parameter logic [ADDR_W-1:0]         CMD_ADDR  = 8'hF0,
   parameter int unsigned               WAIT_CYC  = 3,
   parameter int unsigned               ACC_TO    = 8
) (
   input  logic                 i_clk,
   input  logic                 i_rst,
   rtc_scan_sequencer_if.master bus
);
   localparam int unsigned       WIN_W      = (N_WIN > 1) ? $clog2(N_WIN) : 1;
   localparam int unsigned       CNT_MAX    = (ACC_TO > WAIT_CYC) ? ACC_TO : WAIT_CYC;
   localparam int unsigned       CNT_W      = $clog2(CNT_MAX + 1);
   localparam logic [WIN_W-1:0]  WIN_LAST   = WIN_W'(N_WIN - 1);
   localparam logic [CNT_W-1:0]  ACC_LAST   = CNT_W'(ACC_TO - 1);
   localparam logic [CNT_W-1:0]  PAUSE_LAST = CNT_W'(WAIT_CYC - 1);
   localparam logic [ADDR_W-1:0] START0     = WIN_TABLE[ADDR_W +: ADDR_W];

   typedef enum logic [2:0] {
      ST_INIT, ST_ISSUE, ST_WAIT, ST_NEXT, ST_CMD, ST_CMD_WAIT, ST_DONE, ST_PAUSE
   } state_t;

   // Window w is packed as {start, end} with window 0 in the LSBs
   function automatic logic [ADDR_W-1:0] win_start(input logic [WIN_W-1:0] w);
      return WIN_TABLE[32'(w) * 2 * ADDR_W + ADDR_W +: ADDR_W];
   endfunction

   function automatic logic [ADDR_W-1:0] win_end(input logic [WIN_W-1:0] w);
      return WIN_TABLE[32'(w) * 2 * ADDR_W +: ADDR_W];
   endfunction

   state_t             r_state, w_state_nxt;
   logic               r_acceso, w_acceso_nxt;
   logic               r_mod;
   logic [ADDR_W-1:0]  r_dir, w_dir_nxt;
   logic [ADDR_W-1:0]  r_punt, w_punt_nxt;
   logic [WIN_W-1:0]   r_win_s, w_win_s_nxt;
   logic [WIN_W-1:0]   r_win_p, w_win_p_nxt;
   logic [CNT_W-1:0]   r_cnt, w_cnt_nxt;
   logic               r_scan_done, w_scan_done_nxt;
   logic               r_timeout, w_timeout_nxt;
   logic               w_mod_clr;
   logic [3:0]         r_btn_q;
   logic [3:0]         w_btn, w_edge;
   logic               w_mod_set, w_p_inc, w_p_dec;

   // Button order: {up, down, left, right}; one-stage rising-edge detect
   assign w_btn     = {bus.i_barriba, bus.i_babajo, bus.i_bizquierda, bus.i_bderecha};
   assign w_edge    = w_btn & ~r_btn_q;
   assign w_mod_set = w_edge[3] | w_edge[2] | ~bus.i_irq;
   assign w_p_inc   = w_edge[1] & ~w_edge[0];
   assign w_p_dec   = w_edge[0] & ~w_edge[1];

   // Edit pointer: steps across window boundaries, window index wraps
   always_comb begin
      w_punt_nxt  = r_punt;
      w_win_p_nxt = r_win_p;
      if (w_p_inc) begin
         if (r_punt == win_end(r_win_p)) begin
            w_win_p_nxt = (r_win_p == WIN_LAST) ? '0 : r_win_p + WIN_W'(1);
            w_punt_nxt  = win_start(w_win_p_nxt);
         end else begin
            w_punt_nxt = r_punt + ADDR_W'(1);
         end
      end else if (w_p_dec) begin
         if (r_punt == win_start(r_win_p)) begin
            w_win_p_nxt = (r_win_p == '0) ? WIN_LAST : r_win_p - WIN_W'(1);
            w_punt_nxt  = win_end(w_win_p_nxt);
         end else begin
            w_punt_nxt = r_punt - ADDR_W'(1);
         end
      end
   end

   // Scan FSM next state and next register values
   always_comb begin
      w_state_nxt     = r_state;
      w_acceso_nxt    = r_acceso;
      w_dir_nxt       = r_dir;
      w_win_s_nxt     = r_win_s;
      w_cnt_nxt       = r_cnt;
      w_timeout_nxt   = r_timeout;
      w_scan_done_nxt = 1'b0;
      w_mod_clr       = 1'b0;
      case (r_state)
         ST_INIT: begin
            if (bus.i_frw) w_state_nxt = ST_ISSUE;
         end
         ST_ISSUE, ST_CMD: begin
            w_acceso_nxt = 1'b1;
            w_cnt_nxt    = '0;
            w_state_nxt  = (r_state == ST_CMD) ? ST_CMD_WAIT : ST_WAIT;
         end
         ST_WAIT, ST_CMD_WAIT: begin
            if (bus.i_frw || r_cnt == ACC_LAST) begin
               w_acceso_nxt = 1'b0;
               if (!bus.i_frw) w_timeout_nxt = 1'b1;
               if (r_state == ST_CMD_WAIT) begin
                  w_mod_clr   = bus.i_frw;
                  w_state_nxt = ST_DONE;
               end else begin
                  w_state_nxt = ST_NEXT;
               end
            end else begin
               w_cnt_nxt = r_cnt + CNT_W'(1);
            end
         end
         ST_NEXT: begin
            if (r_dir != win_end(r_win_s)) begin
               w_dir_nxt   = r_dir + ADDR_W'(1);
               w_state_nxt = ST_ISSUE;
            end else if (r_win_s != WIN_LAST) begin
               w_win_s_nxt = r_win_s + WIN_W'(1);
               w_dir_nxt   = win_start(w_win_s_nxt);
               w_state_nxt = ST_ISSUE;
            end else if (r_mod) begin
               w_dir_nxt   = CMD_ADDR;
               w_state_nxt = ST_CMD;
            end else begin
               w_state_nxt = ST_DONE;
            end
         end
         ST_DONE: begin
            w_scan_done_nxt = 1'b1;
            w_dir_nxt       = START0;
            w_win_s_nxt     = '0;
            w_cnt_nxt       = '0;
            w_state_nxt     = ST_PAUSE;
         end
         ST_PAUSE: begin
            if (r_cnt == PAUSE_LAST) begin
               w_cnt_nxt   = '0;
               w_state_nxt = ST_ISSUE;
            end else begin
               w_cnt_nxt = r_cnt + CNT_W'(1);
            end
         end
         default: w_state_nxt = ST_INIT;
      endcase
   end

   // State and output registers; a set request beats a clear on o_mod
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_state     <= ST_INIT;
         r_acceso    <= 1'b0;
         r_mod       <= 1'b1;
         r_dir       <= START0;
         r_punt      <= START0;
         r_win_s     <= '0;
         r_win_p     <= '0;
         r_cnt       <= '0;
         r_scan_done <= 1'b0;
         r_timeout   <= 1'b0;
         r_btn_q     <= '0;
      end else begin
         r_state     <= w_state_nxt;
         r_acceso    <= w_acceso_nxt;
         r_dir       <= w_dir_nxt;
         r_punt      <= w_punt_nxt;
         r_win_s     <= w_win_s_nxt;
         r_win_p     <= w_win_p_nxt;
         r_cnt       <= w_cnt_nxt;
         r_scan_done <= w_scan_done_nxt;
         r_timeout   <= w_timeout_nxt;
         r_btn_q     <= w_btn;
         if (w_mod_set)      r_mod <= 1'b1;
         else if (w_mod_clr) r_mod <= 1'b0;
      end
   end

   assign bus.o_acceso    = r_acceso;
   assign bus.o_mod       = r_mod;
   assign bus.o_dir       = r_dir;
   assign bus.o_punt      = r_punt;
   assign bus.o_scan_done = r_scan_done;
   assign bus.o_timeout   = r_timeout;
endmodule
